// File: rtl/vlog_comment_stripper.sv
// Pre-lexer stage: removes // and /* */ comments from a Verilog byte stream,
// keeps newlines and string literals intact, and tracks the source line number.
module vlog_comment_stripper #(
  parameter int LINE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic [LINE_W-1:0] line_no,
  output logic              err_unterminated,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a port in any cycle where valid and ready are
  // both high at the rising edge; valid never waits on ready, and the output
  // holds data/last stable while out_valid=1 and out_ready=0.

  typedef enum logic [2:0] {
    NORMAL, SLASH, LINE_CMT, BLK_CMT, BLK_STAR, STRING, STR_ESC
  } state_t;

  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_QUOTE = 8'h22;
  localparam logic [7:0] CH_BSL   = 8'h5C;
  localparam logic [7:0] CH_SP    = 8'h20;

  localparam logic [LINE_W-1:0] LINE_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
  localparam logic [LINE_W-1:0] LINE_MAX = {LINE_W{1'b1}};

  state_t     state, state_n;
  logic       can_accept, consume, emit, emit_last, err_n, flush;
  logic [7:0] emit_data;
  logic       is_slash, is_star, is_nl, is_quote, is_bsl;

  assign can_accept = !out_valid || out_ready;
  assign is_slash   = (in_data == CH_SLASH);
  assign is_star    = (in_data == CH_STAR);
  assign is_nl      = (in_data == CH_NL);
  assign is_quote   = (in_data == CH_QUOTE);
  assign is_bsl     = (in_data == CH_BSL);
  assign flush      = (state == SLASH) && in_valid && !is_slash && !is_star;
  assign state_dbg  = state;

  always_comb begin
    state_n   = state;
    emit      = 1'b0;
    emit_data = in_data;
    emit_last = 1'b0;
    err_n     = 1'b0;
    consume   = 1'b0;
    in_ready  = can_accept;
    if (flush) begin
      // A lone '/' is released first; the held byte is re-examined from NORMAL.
      in_ready = 1'b0;
      if (can_accept) begin
        emit      = 1'b1;
        emit_data = CH_SLASH;
        state_n   = NORMAL;
      end
    end else if (in_valid && can_accept) begin
      consume = 1'b1;
      case (state)
        NORMAL: begin
          if (is_slash) state_n = SLASH;
          else begin
            emit = 1'b1;
            if (is_quote) state_n = STRING;
          end
        end
        SLASH:    state_n = is_slash ? LINE_CMT : BLK_CMT;
        LINE_CMT: if (is_nl) begin
          emit    = 1'b1;
          state_n = NORMAL;
        end
        BLK_CMT: begin
          if (is_star) state_n = BLK_STAR;
          else if (is_nl) emit = 1'b1;
        end
        BLK_STAR: begin
          if (is_slash) begin
            emit      = 1'b1;
            emit_data = CH_SP;
            state_n   = NORMAL;
          end else if (is_nl) begin
            emit    = 1'b1;
            state_n = BLK_CMT;
          end else if (!is_star) state_n = BLK_CMT;
        end
        STRING: begin
          emit = 1'b1;
          if (is_bsl) state_n = STR_ESC;
          else if (is_quote) state_n = NORMAL;
        end
        STR_ESC: begin
          emit    = 1'b1;
          state_n = STRING;
        end
        default: state_n = NORMAL;
      endcase
      // The final byte of a file always produces exactly one output byte.
      if (in_last) begin
        state_n   = NORMAL;
        emit      = 1'b1;
        emit_last = 1'b1;
        case (state)
          NORMAL:   emit_data = in_data;
          LINE_CMT: emit_data = CH_NL;
          BLK_CMT: begin
            emit_data = CH_SP;
            err_n     = 1'b1;
          end
          BLK_STAR: begin
            emit_data = CH_SP;
            err_n     = !is_slash;
          end
          STRING: begin
            emit_data = in_data;
            err_n     = !is_quote;
          end
          STR_ESC: begin
            emit_data = in_data;
            err_n     = 1'b1;
          end
          default:  emit_data = CH_SP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= NORMAL;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid        <= 1'b0;
      out_data         <= 8'h00;
      out_last         <= 1'b0;
      err_unterminated <= 1'b0;
      line_no          <= LINE_ONE;
    end else begin
      err_unterminated <= err_n;
      if (can_accept) begin
        out_valid <= emit;
        if (emit) begin
          out_data <= emit_data;
          out_last <= emit_last;
        end
      end
      if (consume) begin
        if (in_last) line_no <= LINE_ONE;
        else if (is_nl && line_no != LINE_MAX) line_no <= line_no + LINE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_vlog_comment_stripper.sv
// Bench for vlog_comment_stripper: directed files plus random files, checked
// against a lookahead-scanning model of the comment/string rules.
module tb_vlog_comment_stripper;

  localparam int LINE_W = 3;
  localparam int LMAX   = 7;
  localparam logic [7:0] C_SL = 8'h2F, C_ST = 8'h2A, C_NL = 8'h0A;
  localparam logic [7:0] C_QU = 8'h22, C_BS = 8'h5C, C_SP = 8'h20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, out_last, err_unterminated;
  logic [7:0] out_data;
  logic [LINE_W-1:0] line_no;
  logic [2:0] state_dbg;

  vlog_comment_stripper #(.LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .line_no(line_no), .err_unterminated(err_unterminated), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] file_b[$];
  bit exp_err;
  int err_seen, stalls, nl_seen, rdy_mode;
  bit mon_en = 1'b1;
  bit hold_prev = 1'b0;
  logic [8:0] prev_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output backpressure patterns: 0 = always ready, 1 = toggle, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (reset_n && mon_en) begin
      if (hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_last, out_data}), 32'(prev_beat));
      end
      if (err_unterminated) err_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat_qsize", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("beat", 32'({out_last, out_data}), 32'(e));
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_beat = {out_last, out_data};
    end else hold_prev = 1'b0;
  end

  function automatic void push(input logic [7:0] d, input bit l);
    exp_q.push_back({l, d});
  endfunction

  // Scans the file with lookahead, one construct at a time.
  function automatic void build_model();
    int n = file_b.size();
    int i = 0;
    int j;
    bit done;
    exp_err = 1'b0;
    while (i < n) begin
      if (file_b[i] == C_SL) begin
        if (i == n - 1) begin
          push(C_SL, 1'b1); i = n;
        end else if (file_b[i+1] == C_SL || file_b[i+1] == C_ST) begin
          if (i + 1 == n - 1) begin
            push(C_SP, 1'b1); i = n;
          end else if (file_b[i+1] == C_SL) begin
            j = i + 2;
            while (!(file_b[j] == C_NL || j == n - 1)) j++;
            push(C_NL, j == n - 1);
            i = j + 1;
          end else begin
            j = i + 2; done = 1'b0;
            while (!done) begin
              if (file_b[j] == C_ST && j + 1 < n && file_b[j+1] == C_SL) begin
                push(C_SP, j + 1 == n - 1); i = j + 2; done = 1'b1;
              end else if (j == n - 1) begin
                push(C_SP, 1'b1); exp_err = 1'b1; i = n; done = 1'b1;
              end else begin
                if (file_b[j] == C_NL) push(C_NL, 1'b0);
                j++;
              end
            end
          end
        end else begin
          push(C_SL, 1'b0); i++;
        end
      end else if (file_b[i] == C_QU) begin
        push(C_QU, i == n - 1);
        j = i + 1; done = (i == n - 1);
        while (!done && j < n) begin
          push(file_b[j], j == n - 1);
          if (file_b[j] == C_BS) begin
            if (j == n - 1) exp_err = 1'b1;
            else begin
              j++;
              push(file_b[j], j == n - 1);
              if (j == n - 1) exp_err = 1'b1;
            end
          end else if (file_b[j] == C_QU) done = 1'b1;
          else if (j == n - 1) exp_err = 1'b1;
          j++;
        end
        i = j;
      end else begin
        push(file_b[i], i == n - 1); i++;
      end
    end
  endfunction

  // Encoded stimulus: L='/', S='*', N=newline, Q=quote, K=backslash.
  task automatic load(input string s);
    logic [7:0] c;
    file_b.delete();
    for (int k = 0; k < s.len(); k++) begin
      c = s[k];
      case (c)
        "L": file_b.push_back(C_SL);
        "S": file_b.push_back(C_ST);
        "N": file_b.push_back(C_NL);
        "Q": file_b.push_back(C_QU);
        "K": file_b.push_back(C_BS);
        default: file_b.push_back(c);
      endcase
    end
  endtask

  task automatic send(input bit do_last, input bit gaps);
    int cyc;
    bit got;
    int exp_line;
    nl_seen = 0;
    stalls = 0;
    for (int k = 0; k < file_b.size(); k++) begin
      in_valid = 1'b1;
      in_data  = file_b[k];
      in_last  = do_last && (k == file_b.size() - 1);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 200) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1'b1;
          exp_line = (1 + nl_seen > LMAX) ? LMAX : 1 + nl_seen;
          check("line_no", 32'(line_no), 32'(exp_line));
          if (in_data == C_NL) nl_seen++;
        end else stalls++;
        cyc++;
        @(posedge clk); #1;
      end
      if (!got) check("byte_timeout_cycles", 32'(cyc), 32'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_file(input int mode, input bit gaps);
    int cyc;
    rdy_mode = mode;
    err_seen = 0;
    exp_q.delete();
    build_model();
    send(1'b1, gaps);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_pulses", 32'(err_seen), 32'(exp_err));
    check("line_no_eof", 32'(line_no), 32'd1);
  endtask

  initial begin
    logic [7:0] alpha [8];
    int len;
    alpha = '{8'h61, 8'h2F, 8'h2A, 8'h22, 8'h5C, 8'h0A, 8'h20, 8'h62};
    rdy_mode = 0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_line_no", 32'(line_no), 32'd1);
    check("rst_err", 32'(err_unterminated), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    load("aLLxNb");           run_file(0, 1'b0);
    load("aLSxNySLb");        run_file(0, 1'b0);
    load("aLb");              run_file(0, 1'b0);
    check("slash_stall_cycles", 32'(stalls), 32'd1);
    load("QLLKQSLQ");         run_file(0, 1'b0);
    load("xLSabc");           run_file(0, 1'b0);
    load("aLSxNySLb");        run_file(1, 1'b0);
    load("NNNNNNNNNNz");      run_file(2, 1'b0);
    load("qL");               run_file(0, 1'b0);
    load("QabK");             run_file(1, 1'b0);
    load("cLL");              run_file(2, 1'b0);

    // Reset in the middle of a block comment.
    mon_en = 1'b0;
    rdy_mode = 0;
    load("aLSxNy");
    send(1'b0, 1'b0);
    check("pre_reset_line", 32'(line_no), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_line_no", 32'(line_no), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    load("SLc");              run_file(0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 24);
      file_b.delete();
      for (int k = 0; k < len; k++) file_b.push_back(alpha[$urandom_range(0, 7)]);
      run_file($urandom_range(0, 2), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
